tx_conv_encoder: RTL
====================

// Module: tx_conv_encoder
// PURPOSE
//   802.11a TX convolutional encoder (K=7, rate 1/2) with puncturing to 2/3 and 3/4.
//   Sits directly downstream of the TX scrambler/controller and consumes its serial
//   scrambled stream. Emits one coded bit per cycle toward the interleaver stage.
// PARAMETERS
//   G0   7'o133  generator for output A; bit 6 taps the current input, bit 0 the oldest state bit
//   G1   7'o171  generator for output B; same tap ordering
// PORTS
//   iClk    in   1  clock, rising edge
//   iRst    in   1  asynchronous, active-low reset
//   iStart  in   1  1-cycle pulse: latch iRate, clear encoder state, enter RUN
//   iRate   in   4  802.11a RATE field; decoded on iStart
//   iValid  in   1  input bit valid
//   iData   in   1  scrambled input bit
//   iLast   in   1  marks the final input bit; qualified by iValid & oReady
//   oReady  out  1  input accepted on the cycle where iValid & oReady is high
//   oData   out  1  coded (punctured) bit
//   oValid  out  1  oData valid
//   oBusy   out  1  high from iStart until oDone
//   oDone   out  1  1-cycle pulse coincident with the last oValid bit of the frame
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; shift reg, queue, phase counter cleared.
//   Rate decode: 1101,0101,1001 -> 1/2; 0001 -> 2/3; 1111,0111,1011,0011 -> 3/4; any other code -> 1/2.
//   FSM: IDLE -(iStart)-> RUN -(iLast accepted)-> DRAIN -(queue empty)-> IDLE, pulsing oDone.
//     An iStart outside IDLE is ignored. iValid in IDLE is ignored and oReady stays 0.
//   Encoder: 6-bit state s, zeroed on iStart. On accept: v = {iData, s}; A = ^(v & G0);
//     B = ^(v & G1); then s <= {iData, s[5:1]}.
//   Puncture phase p: reset to 0 on iStart; advances per accepted bit,
//     mod 1 (1/2), mod 2 (2/3), mod 3 (3/4).
//     Bits pushed per phase: 1/2: A,B. 2/3: p0 A,B; p1 A. 3/4: p0 A,B; p1 A; p2 B.
//   Output queue: 2-entry FIFO with count cnt in 0..2. One bit is popped per cycle while cnt>0.
//     oValid and oData are registered from the queue head.
//     oReady = (state==RUN) && (cnt<=1), a combinational function of registered state.
//     Push and pop in the same cycle are legal; cnt never exceeds 2.
//   Latency: a bit accepted at edge k produces its first coded bit on oValid after edge k+1.
//     A is always emitted before B.
//   Steady throughput: 1/2 accepts one bit every 2 cycles; 3/4 accepts 3 bits per 4 cycles.
//     oValid stays continuous while the source keeps iValid high.
//   Reset mid-frame: immediate abort, everything returns to reset values, no oDone.
// CONFIGURATION
//   CONVENC_TAIL_EN defined: after iLast is accepted, the FSM enters TAIL instead of DRAIN.
//     TAIL internally encodes 6 zero bits, with oReady=0 and puncturing continuing in phase.
//     It then moves to DRAIN. The encoder ends in the zero state without upstream tail bits.
//   CONVENC_TAIL_EN undefined: no TAIL state. Upstream must supply the 6 tail zeros itself.
// TESTING
//   1. Rate 1101, input 1,0,0,0,0,0,0 (iLast on the 7th bit)
//      -> oData 11 01 11 11 00 10 11, 14 bits, oDone on the 14th.
//   2. Rate 1111, same input -> oData 1,1,0,1,1,1,0,0,1,1 (10 bits).
//      Bits per input: 2,1,1,2,1,1,2.
//   3. Rate 0001, input 1,1 -> oData A0=1,B0=1,A1=1 -> 1,1,1 (v=1100000: A=1^0=1).
//      3 bits, then oDone.
//   4. Rate 1101 with iValid held high for 8 bits -> oReady toggles 1,0,1,0...
//      oValid continuous for 16 cycles, no gap and no overflow.
//   5. iRst low mid-frame in rate 3/4 -> next edge: oValid=oBusy=oReady=0, no oDone.
//      A new iStart then reproduces scenario 2 exactly.
//   6. With CONVENC_TAIL_EN, rate 1101, single input 1 with iLast
//      -> 14 output bits identical to scenario 1, oReady=0 during TAIL.

Source files
------------

// File: rtl/tx_conv_encoder.sv
// tx_conv_encoder
//   802.11a transmit convolutional encoder, K=7, mother rate 1/2, with puncturing to
//   2/3 and 3/4. Consumes the serial scrambled stream one bit at a time and emits one
//   coded bit per cycle toward the interleaver.
//
//   Optional feature: define CONVENC_TAIL_EN to have the encoder append the six zero
//   tail bits itself (TAIL state) after iLast is accepted. Without it, the upstream
//   source must supply the tail zeros.
//
// Parameters
//   G0      generator for output A (bit 6 taps the current input, bit 0 the oldest state)
//   G1      generator for output B (same tap ordering)
// Ports
//   iClk    in   clock, rising edge
//   iRst    in   asynchronous active-low reset
//   iStart  in   1-cycle pulse in IDLE: latch iRate, clear encoder state, enter RUN
//   iRate   in   [3:0] 802.11a RATE field, decoded on iStart
//   iValid  in   input bit valid
//   iData   in   scrambled input bit
//   iLast   in   final input bit of the frame, qualified by iValid & oReady
//   oReady  out  input accepted when iValid & oReady
//   oData   out  coded (punctured) bit
//   oValid  out  oData valid
//   oBusy   out  high from iStart through the oDone cycle
//   oDone   out  1-cycle pulse coincident with the last oValid bit of the frame
module tx_conv_encoder #(
  parameter logic [6:0] G0 = 7'o133,
  parameter logic [6:0] G1 = 7'o171
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [3:0] iRate,
  input  logic       iValid,
  input  logic       iData,
  input  logic       iLast,
  output logic       oReady,
  output logic       oData,
  output logic       oValid,
  output logic       oBusy,
  output logic       oDone
);

  typedef enum logic [1:0] {StIdle, StRun, StTail, StDrain} state_e;
  typedef enum logic [1:0] {Rate12, Rate23, Rate34} rate_e;

  function automatic rate_e decode_rate(input logic [3:0] code);
    rate_e r;
    case (code)
      4'b0001:                            r = Rate23;
      4'b1111, 4'b0111, 4'b1011, 4'b0011: r = Rate34;
      default:                            r = Rate12;
    endcase
    return r;
  endfunction

  state_e     state_q, state_d;
  rate_e      rate_q, rate_d;
  logic [5:0] sreg_q, sreg_d;    // sreg_q[5] is the most recent input bit
  logic [1:0] phase_q, phase_d;
  logic [1:0] cnt_q, cnt_d;      // output queue occupancy, 0..2
  logic [1:0] fifo_q, fifo_d;    // fifo_q[0] is the queue head
  logic       data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef CONVENC_TAIL_EN
  logic [2:0] tail_cnt_q, tail_cnt_d;
`endif

  logic       accept, tail_step, enc_en, enc_bit, pop;
  logic       bit_a, bit_b, push_b0, push_b1;
  logic [1:0] push_n, last_phase;
  logic [6:0] enc_vec;

  // Ready depends only on registered state, so upstream sees no combinational path.
  assign oReady = (state_q == StRun) && (cnt_q <= 2'd1);
  assign accept = oReady && iValid;

`ifdef CONVENC_TAIL_EN
  // Tail bits are throttled by the same queue-space rule as real input bits.
  assign tail_step = (state_q == StTail) && (cnt_q <= 2'd1);
`else
  assign tail_step = 1'b0;
`endif

  assign enc_en  = accept || tail_step;
  assign enc_bit = accept && iData;
  assign enc_vec = {enc_bit, sreg_q};
  assign bit_a   = ^(enc_vec & G0);
  assign bit_b   = ^(enc_vec & G1);
  assign pop     = (cnt_q != 2'd0);

  // Puncturing: which coded bits enter the queue for the current phase.
  always_comb begin
    push_n     = 2'd2;
    push_b0    = bit_a;
    push_b1    = bit_b;
    last_phase = 2'd0;
    case (rate_q)
      Rate23: begin
        last_phase = 2'd1;
        if (phase_q != 2'd0) push_n = 2'd1;
      end
      Rate34: begin
        last_phase = 2'd2;
        if (phase_q == 2'd1) begin
          push_n = 2'd1;
        end else if (phase_q == 2'd2) begin
          push_n  = 2'd1;
          push_b0 = bit_b;
        end
      end
      default: ;
    endcase
    if (!enc_en) push_n = 2'd0;
  end

  always_comb begin
    logic [1:0] base_fifo;
    logic [1:0] base_cnt;

    state_d = state_q;
    rate_d  = rate_q;
    sreg_d  = sreg_q;
    phase_d = phase_q;
    done_d  = 1'b0;
`ifdef CONVENC_TAIL_EN
    tail_cnt_d = tail_cnt_q;
`endif

    // Output register takes the queue head every cycle the queue is non-empty.
    valid_d = pop;
    data_d  = pop && fifo_q[0];

    // Pop first, then append; pushes only happen with cnt_q <= 1, so a 2-bit push
    // always lands on an empty post-pop queue.
    if (pop) begin
      base_fifo = {1'b0, fifo_q[1]};
      base_cnt  = cnt_q - 2'd1;
    end else begin
      base_fifo = fifo_q;
      base_cnt  = cnt_q;
    end
    fifo_d = base_fifo;
    cnt_d  = base_cnt + push_n;
    if (push_n == 2'd2) begin
      fifo_d = {push_b1, push_b0};
    end else if (push_n == 2'd1) begin
      fifo_d[base_cnt[0]] = push_b0;
    end

    if (enc_en) begin
      sreg_d  = {enc_bit, sreg_q[5:1]};
      phase_d = (phase_q == last_phase) ? 2'd0 : phase_q + 2'd1;
    end

    case (state_q)
      StIdle: begin
        if (iStart) begin
          state_d = StRun;
          rate_d  = decode_rate(iRate);
          sreg_d  = '0;
          phase_d = '0;
          cnt_d   = '0;
          fifo_d  = '0;
        end
      end
      StRun: begin
        if (accept && iLast) begin
`ifdef CONVENC_TAIL_EN
          state_d    = StTail;
          tail_cnt_d = '0;
`else
          state_d = StDrain;
`endif
        end
      end
`ifdef CONVENC_TAIL_EN
      StTail: begin
        if (tail_step) begin
          tail_cnt_d = tail_cnt_q + 3'd1;
          if (tail_cnt_q == 3'd5) state_d = StDrain;
        end
      end
`endif
      StDrain: begin
        // The bit popped now is the last one; oDone rises with it.
        if (cnt_q == 2'd1) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == 2'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle) || done_d;
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state_q    <= StIdle;
      rate_q     <= Rate12;
      sreg_q     <= '0;
      phase_q    <= '0;
      cnt_q      <= '0;
      fifo_q     <= '0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CONVENC_TAIL_EN
      tail_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      sreg_q     <= sreg_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      fifo_q     <= fifo_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CONVENC_TAIL_EN
      tail_cnt_q <= tail_cnt_d;
`endif
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oDone  = done_q;

endmodule
